pipe_scoreboard: RTL and testbench

Parametrised hazard and forwarding scoreboard for the pipelined CPU. It sits beside the ID stage and tracks every in-flight register writer across `STAGES` post-ID pipeline slots, each with its own result-ready stage. It replaces the fixed EX/MEM–MEM/WB forwarding compare and load-use detect: it raises a combinational stall for the ID instruction and emits registered forward selects aligned with the EX stage. It also handles flush of younger slots, an external freeze, and a stall-cycle counter.

---
 rtl/pipe_pkg.sv | 31 +++
 rtl/pipe_sb_match.sv | 44 ++++
 rtl/pipe_scoreboard.sv | 143 ++++++++++++++
 tb/tb_pipe_scoreboard.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding scoreboard.
// Contents:
//   FWD_*       forward-select encodings (0 = ID/EX register data, k = pipeline register k)
//   RDY_*       first slot at which a result can be forwarded (ALU / load)
//   slot_t      one tracked in-flight instruction {valid, we, dst, rdy}
//   SLOT_EMPTY  bubble value for a slot
// The slot fields are sized for the widest supported configuration
// (REG_ADDR_W <= SLOT_ADDR_W, STAGES <= 2**SLOT_SEL_W). Narrower
// instances zero-extend into them.
package pipe_pkg;

   localparam int unsigned FWD_RF    = 0;
   localparam int unsigned FWD_EXMEM = 1;
   localparam int unsigned FWD_MEMWB = 2;

   localparam int unsigned RDY_ALU  = 1;
   localparam int unsigned RDY_LOAD = 2;

   localparam int unsigned SLOT_ADDR_W = 8;
   localparam int unsigned SLOT_SEL_W  = 4;

   typedef struct packed {
      logic                   valid;
      logic                   we;
      logic [SLOT_ADDR_W-1:0] dst;
      logic [SLOT_SEL_W-1:0]  rdy;
   } slot_t;

   localparam slot_t SLOT_EMPTY = '0;

endpackage

// File: rtl/pipe_sb_match.sv
// Youngest-producer search for one source operand.
// Ports:
//   slots_i   searchable slots 0..STAGES-2 (slot 0 youngest); the last slot is
//             covered by the write-through register file and is not passed in
//   use_i     the ID instruction reads this operand
//   src_i     source register address
//   sel_o     forward select for EX next cycle (0 = register data)
//   hazard_o  youngest producer will not be ready in time; the consumer must stall
module pipe_sb_match
   import pipe_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned STAGES     = 3,
   parameter int unsigned SEL_W      = $clog2(STAGES)
)(
   input  slot_t [STAGES-2:0]     slots_i,
   input  logic                   use_i,
   input  logic [REG_ADDR_W-1:0]  src_i,
   output logic [SEL_W-1:0]       sel_o,
   output logic                   hazard_o
);

   // Walk from oldest to youngest so the youngest match overwrites any older one.
   // A producer in slot j-1 sits in slot j when the consumer reaches EX.
   always_comb begin
      sel_o    = SEL_W'(FWD_RF);
      hazard_o = 1'b0;
      if (use_i && (src_i != '0)) begin
         for (int unsigned j = STAGES - 1; j > 0; j--) begin
            if (slots_i[j-1].valid && slots_i[j-1].we &&
                (slots_i[j-1].dst == SLOT_ADDR_W'(src_i))) begin
               if (j >= 32'(slots_i[j-1].rdy)) begin
                  sel_o    = SEL_W'(j);
                  hazard_o = 1'b0;
               end else begin
                  sel_o    = SEL_W'(FWD_RF);
                  hazard_o = 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/pipe_scoreboard.sv
// Hazard and forwarding scoreboard beside the ID stage.
// Tracks every in-flight register writer across STAGES post-ID slots
// (slot 0 = ID/EX, 1 = EX/MEM, 2 = MEM/WB, ...), raises a combinational
// stall for the ID instruction and registers forward selects aligned with EX.
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   issue_valid_i/we_i/dst_i   ID instruction and its destination
//   issue_rdy_i                first slot at which its result is forwardable
//   use_rs_i/rs_i, use_rt_i/rt_i  source operands of the ID instruction
//   flush_i                    taken branch: drop ID instruction, kill young slots
//   hold_i                     external freeze: no state change
//   stall_o                    combinational hazard for the ID instruction
//   fwd_a_o, fwd_b_o           registered EX operand selects
//   inflight_o                 number of valid writer slots
//   stall_cnt_o                saturating count of stalled cycles
module pipe_scoreboard
   import pipe_pkg::*;
#(
   parameter int unsigned REG_ADDR_W  = 5,
   parameter int unsigned STAGES      = 3,
   parameter int unsigned FLUSH_DEPTH = 2,
   parameter int unsigned SEL_W       = $clog2(STAGES),
   parameter int unsigned CNT_W       = 16
)(
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         issue_valid_i,
   input  logic                         issue_we_i,
   input  logic [REG_ADDR_W-1:0]        issue_dst_i,
   input  logic [SEL_W-1:0]             issue_rdy_i,
   input  logic                         use_rs_i,
   input  logic                         use_rt_i,
   input  logic [REG_ADDR_W-1:0]        rs_i,
   input  logic [REG_ADDR_W-1:0]        rt_i,
   input  logic                         flush_i,
   input  logic                         hold_i,
   output logic                         stall_o,
   output logic [SEL_W-1:0]             fwd_a_o,
   output logic [SEL_W-1:0]             fwd_b_o,
   output logic [$clog2(STAGES+1)-1:0]  inflight_o,
   output logic [CNT_W-1:0]             stall_cnt_o
);

   localparam int unsigned INF_W = $clog2(STAGES + 1);

   slot_t [STAGES-1:0] slot_q, slot_d;
   logic [SEL_W-1:0]   fwd_a_q, fwd_a_d;
   logic [SEL_W-1:0]   fwd_b_q, fwd_b_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [INF_W-1:0]   inflight;

   logic [SEL_W-1:0]   sel_a, sel_b;
   logic               haz_a, haz_b;
   logic               stall;
   logic               accept;

   pipe_sb_match #(
      .REG_ADDR_W (REG_ADDR_W),
      .STAGES     (STAGES),
      .SEL_W      (SEL_W)
   ) u_match_rs (
      .slots_i  (slot_q[STAGES-2:0]),
      .use_i    (use_rs_i),
      .src_i    (rs_i),
      .sel_o    (sel_a),
      .hazard_o (haz_a)
   );

   pipe_sb_match #(
      .REG_ADDR_W (REG_ADDR_W),
      .STAGES     (STAGES),
      .SEL_W      (SEL_W)
   ) u_match_rt (
      .slots_i  (slot_q[STAGES-2:0]),
      .use_i    (use_rt_i),
      .src_i    (rt_i),
      .sel_o    (sel_b),
      .hazard_o (haz_b)
   );

   // Flush overrides the hazard: the instruction is dropped, not stalled.
   assign stall  = issue_valid_i & ~flush_i & (haz_a | haz_b);
   assign accept = issue_valid_i & ~flush_i & ~stall;

   always_comb begin
      slot_d  = slot_q;
      fwd_a_d = fwd_a_q;
      fwd_b_d = fwd_b_q;
      cnt_d   = cnt_q;
      if (!hold_i) begin
         // Shift older; on flush the young entries moving into slots
         // 1..FLUSH_DEPTH-1 are killed in transit.
         for (int unsigned j = 1; j < STAGES; j++) begin
            slot_d[j] = slot_q[j-1];
            if (flush_i && (j < FLUSH_DEPTH)) begin
               slot_d[j].valid = 1'b0;
            end
         end
         slot_d[0] = SLOT_EMPTY;
         if (accept) begin
            slot_d[0] = '{valid: 1'b1,
                          we:    issue_we_i,
                          dst:   SLOT_ADDR_W'(issue_dst_i),
                          rdy:   SLOT_SEL_W'(issue_rdy_i)};
         end
         fwd_a_d = accept ? sel_a : SEL_W'(FWD_RF);
         fwd_b_d = accept ? sel_b : SEL_W'(FWD_RF);
         if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         slot_q  <= '0;
         fwd_a_q <= '0;
         fwd_b_q <= '0;
         cnt_q   <= '0;
      end else begin
         slot_q  <= slot_d;
         fwd_a_q <= fwd_a_d;
         fwd_b_q <= fwd_b_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      inflight = '0;
      for (int unsigned j = 0; j < STAGES; j++) begin
         if (slot_q[j].valid && slot_q[j].we) begin
            inflight = inflight + INF_W'(1);
         end
      end
   end

   assign stall_o     = stall;
   assign fwd_a_o     = fwd_a_q;
   assign fwd_b_o     = fwd_b_q;
   assign inflight_o  = inflight;
   assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Bench for pipe_scoreboard: directed vector table, a saturation sequence and
// randomized traffic, all checked against a queue-based reference model.
// Two instances share stimulus; the second narrows the stall counter to 4 bits.
module tb_pipe_scoreboard;
   import pipe_pkg::*;

   localparam int AW  = 5;
   localparam int ST  = 3;
   localparam int FD  = 2;
   localparam int SW  = $clog2(ST);
   localparam int IW  = $clog2(ST + 1);
   localparam int CW  = 16;
   localparam int CW4 = 4;

   logic          clk = 1'b0;
   logic          rst, iv, iwe, urs, urt, fl, hd;
   logic [AW-1:0] idst, rs, rt;
   logic [SW-1:0] irdy;

   logic          stall, stall4;
   logic [SW-1:0] fa, fb, fa4, fb4;
   logic [IW-1:0] inf, inf4;
   logic [CW-1:0] cnt;
   logic [CW4-1:0] cnt4;

   always #5 clk = ~clk;

   pipe_scoreboard #(
      .REG_ADDR_W (AW), .STAGES (ST), .FLUSH_DEPTH (FD), .SEL_W (SW), .CNT_W (CW)
   ) dut (
      .clk_i (clk), .rst_i (rst), .issue_valid_i (iv), .issue_we_i (iwe),
      .issue_dst_i (idst), .issue_rdy_i (irdy), .use_rs_i (urs), .use_rt_i (urt),
      .rs_i (rs), .rt_i (rt), .flush_i (fl), .hold_i (hd), .stall_o (stall),
      .fwd_a_o (fa), .fwd_b_o (fb), .inflight_o (inf), .stall_cnt_o (cnt)
   );

   pipe_scoreboard #(
      .REG_ADDR_W (AW), .STAGES (ST), .FLUSH_DEPTH (FD), .SEL_W (SW), .CNT_W (CW4)
   ) dut4 (
      .clk_i (clk), .rst_i (rst), .issue_valid_i (iv), .issue_we_i (iwe),
      .issue_dst_i (idst), .issue_rdy_i (irdy), .use_rs_i (urs), .use_rt_i (urt),
      .rs_i (rs), .rt_i (rt), .flush_i (fl), .hold_i (hd), .stall_o (stall4),
      .fwd_a_o (fa4), .fwd_b_o (fb4), .inflight_o (inf4), .stall_cnt_o (cnt4)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input int exp);
      n_cmp++;
      if (act !== 32'(exp)) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // The pipeline is a queue of instructions, front = youngest (ID/EX).
   typedef struct {
      bit valid;
      bit we;
      int dst;
      int rdy;
   } ment_t;

   ment_t mq[$];
   int    m_fa, m_fb, m_cnt, m_cnt4;

   function automatic ment_t bubble();
      ment_t b;
      b = '{valid: 1'b0, we: 1'b0, dst: 0, rdy: 0};
      return b;
   endfunction

   function automatic void m_reset();
      mq.delete();
      for (int i = 0; i < ST; i++) mq.push_back(bubble());
      m_fa = 0; m_fb = 0; m_cnt = 0; m_cnt4 = 0;
   endfunction

   function automatic int m_inflight();
      int n = 0;
      foreach (mq[i]) if (mq[i].valid && mq[i].we) n++;
      return n;
   endfunction

   // Nearest older writer of x; it is distance pos+1 ahead of the consumer in EX.
   // The oldest queue entry is already in write-back and never forwarded.
   function automatic void m_lookup(input bit use_x, input int x,
                                    output int sel, output bit haz);
      int idx[$];
      sel = 0;
      haz = 1'b0;
      if (!use_x || x == 0) return;
      idx = mq.find_first_index with (item.valid && item.we && item.dst == x);
      if (idx.size() == 0) return;
      if (idx[0] > ST - 2) return;
      if (idx[0] + 1 >= mq[idx[0]].rdy) sel = idx[0] + 1;
      else haz = 1'b1;
   endfunction

   // One clock: check outputs against the model, then advance model and DUT.
   task automatic cycle(input bit do_chk);
      int sa, sb;
      bit ha, hb, m_stall, acc;
      ment_t e;
      #1;
      m_lookup(urs, int'(rs), sa, ha);
      m_lookup(urt, int'(rt), sb, hb);
      m_stall = iv && !fl && (ha || hb);
      if (do_chk) begin
         chk("model_stall",  32'(stall),  int'(m_stall));
         chk("model_stall4", 32'(stall4), int'(m_stall));
         chk("model_fwd_a",  32'(fa),     m_fa);
         chk("model_fwd_b",  32'(fb),     m_fb);
         chk("model_inflight", 32'(inf),  m_inflight());
         chk("model_cnt",    32'(cnt),    m_cnt);
         chk("model_cnt4",   32'(cnt4),   m_cnt4);
      end
      @(posedge clk);
      if (rst) begin
         m_reset();
      end else if (!hd) begin
         acc = iv && !fl && !m_stall;
         if (fl) for (int i = 0; i < FD - 1; i++) mq[i].valid = 1'b0;
         e = bubble();
         if (acc) e = '{valid: 1'b1, we: iwe, dst: int'(idst), rdy: int'(irdy)};
         mq.push_front(e);
         void'(mq.pop_back());
         m_fa = acc ? sa : 0;
         m_fb = acc ? sb : 0;
         if (m_stall) begin
            if (m_cnt < (1 << CW) - 1) m_cnt++;
            if (m_cnt4 < (1 << CW4) - 1) m_cnt4++;
         end
      end
      @(negedge clk);
   endtask

   task automatic drive(input bit r, input bit v, input bit we, input int dst, input int rdy,
                        input bit ua, input int a, input bit ub, input int b,
                        input bit f, input bit h);
      rst = r; iv = v; iwe = we; idst = AW'(dst); irdy = SW'(rdy);
      urs = ua; rs = AW'(a); urt = ub; rt = AW'(b); fl = f; hd = h;
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      bit r, v, we; int dst, rdy;
      bit ua; int a; bit ub; int b;
      bit f, h;
      int e_stall, e_fa, e_fb, e_inf, e_cnt;
   } vec_t;

   vec_t tbl[$];

   function automatic void row(bit r, bit v, bit we, int dst, int rdy,
                               bit ua, int a, bit ub, int b, bit f, bit h,
                               int es, int efa, int efb, int einf, int ecnt);
      vec_t t;
      t = '{r: r, v: v, we: we, dst: dst, rdy: rdy, ua: ua, a: a, ub: ub, b: b,
            f: f, h: h, e_stall: es, e_fa: efa, e_fb: efb, e_inf: einf, e_cnt: ecnt};
      tbl.push_back(t);
   endfunction

   initial begin
      //  r v we dst rdy  ua a  ub b  f h   stall fa fb inf cnt
      row(1,0,0, 0,0,   0,0, 0,0, 0,0,  0,0,0,0,0);  // reset state
      row(0,1,1, 5,1,   0,0, 0,0, 0,0,  0,0,0,0,0);  // r5 <- ALU
      row(0,1,0, 0,0,   1,5, 0,0, 0,0,  0,0,0,1,0);  // reads r5: no stall
      row(0,0,0, 0,0,   0,0, 0,0, 0,0,  0,1,0,1,0);  // fwd_a = EX/MEM
      row(0,1,1, 5,2,   0,0, 0,0, 0,0,  0,0,0,1,0);  // r5 <- load
      row(0,1,0, 0,0,   0,0, 1,5, 0,0,  1,0,0,1,0);  // load-use: stall
      row(0,1,0, 0,0,   0,0, 1,5, 0,0,  0,0,0,1,1);  // retry accepted
      row(0,0,0, 0,0,   0,0, 0,0, 0,0,  0,0,2,1,1);  // fwd_b = MEM/WB
      row(0,1,1, 0,2,   0,0, 0,0, 0,0,  0,0,0,0,1);  // load to r0
      row(0,1,0, 0,0,   1,0, 1,0, 0,0,  0,0,0,1,1);  // reads r0: ignored
      row(0,1,1, 7,2,   0,0, 0,0, 0,0,  0,0,0,1,1);  // r7 <- load
      row(0,1,1, 7,1,   0,0, 0,0, 0,0,  0,0,0,2,1);  // r7 <- ALU (younger)
      row(0,1,0, 0,0,   1,7, 0,0, 0,0,  0,0,0,2,1);  // reads r7
      row(0,0,0, 0,0,   0,0, 0,0, 0,0,  0,1,0,2,1);  // youngest wins: 1
      row(0,1,1, 9,2,   0,0, 0,0, 0,0,  0,0,0,1,1);  // r9 <- load
      row(0,1,0, 0,0,   1,9, 0,0, 1,0,  0,0,0,1,1);  // flush on hazard
      row(0,0,0, 0,0,   0,0, 0,0, 0,0,  0,0,0,0,1);  // young slots killed
      row(0,1,1, 3,2,   0,0, 0,0, 0,0,  0,0,0,0,1);  // r3 <- load
      row(0,1,0, 0,0,   1,3, 0,0, 0,1,  1,0,0,1,1);  // hold x3, stall visible
      row(0,1,0, 0,0,   1,3, 0,0, 0,1,  1,0,0,1,1);
      row(0,1,0, 0,0,   1,3, 0,0, 0,1,  1,0,0,1,1);
      row(0,1,0, 0,0,   1,3, 0,0, 0,0,  1,0,0,1,1);  // release: counted
      row(0,1,0, 0,0,   1,3, 0,0, 0,0,  0,0,0,1,2);
      row(0,0,0, 0,0,   0,0, 0,0, 0,0,  0,2,0,1,2);
      row(0,1,1, 4,2,   0,0, 0,0, 0,0,  0,0,0,0,2);  // r4 <- load
      row(1,1,0, 0,0,   0,0, 1,4, 0,0,  1,0,0,1,2);  // reset mid-stall
      row(0,1,0, 0,0,   0,0, 1,4, 0,0,  0,0,0,0,0);  // clean after reset
      row(0,0,0, 0,0,   0,0, 0,0, 0,0,  0,0,0,0,0);

      drive(1,0,0,0,0, 0,0,0,0, 0,0);
      cycle(1'b0);

      foreach (tbl[i]) begin
         drive(tbl[i].r, tbl[i].v, tbl[i].we, tbl[i].dst, tbl[i].rdy,
               tbl[i].ua, tbl[i].a, tbl[i].ub, tbl[i].b, tbl[i].f, tbl[i].h);
         #1;
         chk($sformatf("vec%0d_stall", i),    32'(stall), tbl[i].e_stall);
         chk($sformatf("vec%0d_fwd_a", i),    32'(fa),    tbl[i].e_fa);
         chk($sformatf("vec%0d_fwd_b", i),    32'(fb),    tbl[i].e_fb);
         chk($sformatf("vec%0d_inflight", i), 32'(inf),   tbl[i].e_inf);
         chk($sformatf("vec%0d_cnt", i),      32'(cnt),   tbl[i].e_cnt);
         chk($sformatf("vec%0d_cnt4", i),     32'(cnt4),  tbl[i].e_cnt);
         cycle(1'b1);
      end

      // Self-dependent load repeated back to back: stalls every other cycle.
      drive(1,0,0,0,0, 0,0,0,0, 0,0);
      cycle(1'b1);
      for (int i = 0; i < 40; i++) begin
         drive(0,1,1,5,RDY_LOAD, 1,5,0,0, 0,0);
         cycle(1'b1);
      end
      drive(0,0,0,0,0, 0,0,0,0, 0,0);
      #1;
      chk("sat_cnt16", 32'(cnt),  20);
      chk("sat_cnt4",  32'(cnt4), 15);
      cycle(1'b1);
      drive(1,0,0,0,0, 0,0,0,0, 0,0);
      cycle(1'b1);
      drive(0,0,0,0,0, 0,0,0,0, 0,0);
      #1;
      chk("sat_reset_cnt16", 32'(cnt),  0);
      chk("sat_reset_cnt4",  32'(cnt4), 0);
      cycle(1'b1);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(0, 99) == 0),
               ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 3) != 0),
               int'($urandom_range(0, 7)),
               int'($urandom_range(0, 3)),
               ($urandom_range(0, 1) == 1), int'($urandom_range(0, 7)),
               ($urandom_range(0, 1) == 1), int'($urandom_range(0, 7)),
               ($urandom_range(0, 9) == 0),
               ($urandom_range(0, 7) == 0));
         cycle(1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
